// File: rtl/latch_write_sequencer.sv
// Drives a latch D bus and a glitch-free EN strobe as setup / pulse / hold around each accepted write.
// Optional readback compare of Q against D in the DONE cycle: LATCH_WRITE_SEQUENCER_READBACK_CHECK_EN.
module latch_write_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] D,
  output logic             EN,
  input  logic [WIDTH-1:0] Q,
  output logic             wr_done,
  output logic             err,
  output logic [2:0]       dbg_state_o
);

  // Handshake: a write is accepted on a rising edge where wr_valid=1 and wr_ready=1 (IDLE only);
  // wr_valid/wr_data are ignored in every other state and nothing is queued.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = $clog2(MAXC + 1);

  localparam int SETUP_LAST_I = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
  localparam int PULSE_LAST_I = (PULSE_CYC > 0) ? PULSE_CYC - 1 : 0;
  localparam int HOLD_LAST_I  = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_LAST_I);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LAST_I);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_LAST_I);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             accept;

  // State register: EN and wr_done are flops loaded from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // Next-state: the counter restarts at 0 on every state entry and stops at the phase's last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_valid) state_d = (SETUP_CYC > 0) ? S_SETUP : S_PULSE;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_PULSE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) state_d = (HOLD_CYC > 0) ? S_HOLD : S_DONE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_DONE;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: next values for the output flops plus the IDLE-derived ready.
  always_comb begin
    accept   = (state_q == S_IDLE) && wr_valid;
    wr_ready = (state_q == S_IDLE);
    en_d     = (state_d == S_PULSE);
    done_d   = (state_d == S_DONE);
    d_d      = accept ? wr_data : d_q;
  end

  assign D           = d_q;
  assign EN          = en_q;
  assign wr_done     = done_q;
  assign dbg_state_o = state_q;

`ifdef LATCH_WRITE_SEQUENCER_READBACK_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | ((state_q == S_DONE) && (Q != d_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic q_unused;
  assign q_unused = ^Q;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: two instances (default timing and zero-width setup/hold)
// share stimulus; a cycle-index reference model and a completion queue check them.
module tb_latch_write_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       q_zero;

  logic       ready_o[2];
  logic [7:0] d_o[2];
  logic       en_o[2];
  logic [7:0] q_in[2];
  logic       done_o[2];
  logic       err_o[2];
  logic [2:0] dbg_unused[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef LATCH_WRITE_SEQUENCER_READBACK_CHECK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  // Phase lengths of each instance.
  int sc[2] = '{1, 0};
  int pc[2] = '{2, 1};
  int hc[2] = '{1, 0};

  // Reference model: busy flag, cycle index k since accept, latched word, sticky error.
  bit         busy_m[2] = '{1'b0, 1'b0};
  int         k_m[2]    = '{0, 0};
  logic [7:0] d_m[2]    = '{8'h00, 8'h00};
  bit         err_m[2]  = '{1'b0, 1'b0};

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         cyc_q0[$];
  int         cyc_q1[$];

  always #5 clk = ~clk;

  assign q_in[0] = q_zero ? 8'h00 : d_o[0];
  assign q_in[1] = q_zero ? 8'h00 : d_o[1];

  latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_def (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_o[0]), .wr_data(wr_data),
    .D(d_o[0]), .EN(en_o[0]), .Q(q_in[0]), .wr_done(done_o[0]), .err(err_o[0]),
    .dbg_state_o(dbg_unused[0])
  );

  latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u_zero (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_o[1]), .wr_data(wr_data),
    .D(d_o[1]), .EN(en_o[1]), .Q(q_in[1]), .wr_done(done_o[1]), .err(err_o[1]),
    .dbg_state_o(dbg_unused[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy_m[i] = 1'b0;
      k_m[i]    = 0;
      d_m[i]    = 8'h00;
      err_m[i]  = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
    cyc_q0.delete();
    cyc_q1.delete();
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        int last;
        last = sc[i] + pc[i] + hc[i];
        if (READBACK && busy_m[i] && k_m[i] == last && q_zero && d_m[i] != 8'h00) err_m[i] = 1'b1;
        if (!busy_m[i]) begin
          if (wr_valid) begin
            busy_m[i] = 1'b1;
            k_m[i]    = 0;
            d_m[i]    = wr_data;
            if (i == 0) begin exp_q0.push_back(wr_data); cyc_q0.push_back(cyc + last); end
            else        begin exp_q1.push_back(wr_data); cyc_q1.push_back(cyc + last); end
          end
        end else if (k_m[i] == last) begin
          busy_m[i] = 1'b0;
        end else begin
          k_m[i]++;
        end
      end
    end
  end

  // Monitor: per-cycle output compare, and queue pop whenever a DUT reports completion.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit   en_e;
      bit   done_e;
      logic [7:0] ed;
      int   ec;
      en_e   = busy_m[i] && k_m[i] >= sc[i] && k_m[i] < sc[i] + pc[i];
      done_e = busy_m[i] && k_m[i] == sc[i] + pc[i] + hc[i];
      chk("ready", i, ready_o[i], !busy_m[i]);
      chk("en", i, en_o[i], en_e);
      chk("done", i, done_o[i], done_e);
      chk("d", i, d_o[i], d_m[i]);
      chk("err", i, err_o[i], err_m[i]);
      if (done_o[i]) begin
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL done_spurious inst%0d cyc=%0d: got wr_done=1 expected no pending write", i, cyc);
        end else begin
          if (i == 0) begin ed = exp_q0.pop_front(); ec = cyc_q0.pop_front(); end
          else        begin ed = exp_q1.pop_front(); ec = cyc_q1.pop_front(); end
          chk("done_data", i, d_o[i], ed);
          chk("done_cycle", i, cyc, ec);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_check();
    for (int i = 0; i < 2; i++) begin
      chk("rst_en", i, en_o[i], 1'b0);
      chk("rst_d", i, d_o[i], 8'h00);
      chk("rst_done", i, done_o[i], 1'b0);
      chk("rst_err", i, err_o[i], 1'b0);
      chk("rst_ready", i, ready_o[i], 1'b1);
    end
  endtask

  task automatic write1(input logic [7:0] data, input int tail);
    wr_valid = 1'b1;
    wr_data  = data;
    step(1);
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
    step(tail);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'($urandom);
    q_zero   = 1'b1;
    #2;
    rst_check();
    step(2);
    wr_valid = 1'b0;
    q_zero   = 1'b0;
    rst_n    = 1'b1;
    step(2);

    // Single write, then zero-width-phase word.
    write1(8'hA5, 8);
    write1(8'h3C, 8);

    // Back-to-back with wr_valid held; data changes in cycle 2.
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    step(3);
    wr_data  = 8'h22;
    step(6);
    wr_valid = 1'b0;
    step(8);

    // Reset during the first EN-high cycle of the default instance.
    write1(8'hFF, 1);
    rst_n = 1'b0;
    #1;
    rst_check();
    step(2);
    rst_n = 1'b1;
    step(1);
    write1(8'h0F, 8);

    // Readback: forced-zero Q, then a matching write; then a fresh reset with matching Q.
    q_zero = 1'b1;
    write1(8'h3C, 8);
    q_zero = 1'b0;
    write1(8'h3C, 8);
    rst_n = 1'b0;
    #1;
    rst_check();
    step(1);
    rst_n = 1'b1;
    write1(8'h3C, 8);

    // Randomized traffic with occasional forced-Q mismatches and resets.
    for (int n = 0; n < 600; n++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
      q_zero   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_check();
        step(1);
        rst_n = 1'b1;
      end
      step(1);
    end
    wr_valid = 1'b0;
    q_zero   = 1'b0;
    step(10);

    chk("drain_q", 0, exp_q0.size(), 0);
    chk("drain_q", 1, exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
